posit_mult_decoded: RTL and testbench
=====================================

Name: posit_mult_decoded

Overview:
- Pipelined multiplier on decoded posit operands.
- Consumes two operand sets of sign/inf/zero/scale/fraction from the posit denormalize stages.
- Produces the exact (unrounded) decoded product for the downstream normalize/round/encode stage.
- Two register stages with rts/rtr flow control on both sides.

Parameters:
- POSIT_WIDTH, 16, posit word width N (N >= 8).
- POSIT_ES, 0, exponent field width (0..3).
- Derived SW = $clog2(POSIT_WIDTH-1)+POSIT_ES+1: operand scale width, signed two's complement.
- Derived FW = POSIT_WIDTH-3-POSIT_ES: operand fraction width, hidden bit excluded.
- Derived PFW = 2*FW+1: product fraction width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- rts_i  in  1  upstream has a valid operand pair.
- rtr_o  out  1  block accepts an operand pair this cycle.
- a_sign, b_sign  in  1 each  operand signs.
- a_inf, b_inf  in  1 each  operand is NaR.
- a_zero, b_zero  in  1 each  operand is zero.
- a_scale, b_scale  in  SW each  signed operand scales.
- a_fraction, b_fraction  in  FW each  operand fractions, MSB-aligned.
- rts_o  out  1  product valid.
- rtr_i  in  1  downstream accepts product.
- sign  out  1  product sign.
- inf  out  1  product is NaR.
- zero  out  1  product is zero.
- scale  out  SW+1  signed product scale.
- fraction  out  PFW  normalized product fraction, hidden bit removed.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valids 0. rts_o=0. sign, inf, zero, scale and fraction registers all 0.
- Handshake:
  - Transfer in when rts_i & rtr_o.
  - Transfer out when rts_o & rtr_i.
  - Stage enables: s2_en = !s2_v | rtr_i; s1_en = !s1_v | s2_en; rtr_o = s1_en (combinational from rtr_i).
  - rtr_o is 1 while reset is asserted.
- Latency and throughput: 2 cycles, input accept to rts_o. Throughput 1 product per cycle when rtr_i=1.
- Stall: with rtr_i=0, two pairs are held and rtr_o drops. Outputs are stable while rts_o & !rtr_i.
- Stage 1 registers:
  - sign_x = a_sign^b_sign.
  - inf_x = a_inf|b_inf.
  - zero_x = !inf_x & (a_zero|b_zero).
  - scale_sum = sign-extended a_scale + b_scale, SW+1 bits, no overflow possible.
  - mant = {1,a_fraction} * {1,b_fraction}, 2FW+2 bits unsigned.
- Stage 2, normalize:
  - If mant[MSB]=1: scale = scale_sum+1, fraction = mant[PFW-1:0].
  - Else: scale = scale_sum, fraction = {mant[PFW-2:0],1'b0}.
- Specials:
  - inf=1 or zero=1 forces sign=0, scale=0, fraction=0.
  - inf has priority over zero.
- Operand bits are ignored when rts_i=0. Registers hold when not enabled.
- Simultaneous accept and emit in one cycle is legal; no bubble is inserted.
- rst asserted mid-stream discards all in-flight pairs. rts_o=0 the following cycle.

Optional Feature:
- Macro: POSIT_MULT_STATS_EN.
- When defined:
  - Adds output nar_count [15:0], a saturating count of products emitted with inf=1.
  - Adds output prod_count [31:0], a saturating count of all products emitted.
  - Both increment on the output transfer cycle, hold at all-ones, and reset to 0.
- When undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- N=16, ES=0: a=b={s0, scale 0, frac 0x1000} (1.5), rtr_i=1 -> after 2 cycles rts_o=1, sign=0, scale=1, fraction=0x1000000 (2.25).
- a={s1, scale 3, frac 0}, b={s0, scale -2, frac 0} -> sign=1, scale=1, fraction=0, inf=0, zero=0.
- a_inf=1 with b_zero=1 -> inf=1, zero=0, sign=0, scale=0, fraction=0. Then a_zero=1 with b normal -> zero=1, all other fields 0.
- Stream 5 pairs back-to-back, rtr_i=0 from cycle 3 to cycle 6 -> rtr_o=0 once both stages are full, outputs stable during the stall, all 5 products emitted in order with no loss or duplication.
- Assert rst for 1 cycle with 2 pairs in flight -> rts_o=0 the next cycle, no stale product emitted, rtr_o=1.
- With POSIT_MULT_STATS_EN defined: 3 NaR plus 4 normal products -> nar_count=3, prod_count=7. Preload nar_count near 0xFFFF -> count saturates at 0xFFFF.

Source files
------------

// File: rtl/posit_mult_decoded_if.sv
// Operand/product bus for the decoded posit multiplier: upstream rts/rtr pair,
// two decoded operands, downstream rts/rtr pair and the decoded product.
interface posit_mult_decoded_if #(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 0
);
  localparam int SW  = $clog2(POSIT_WIDTH-1) + POSIT_ES + 1;
  localparam int FW  = POSIT_WIDTH - 3 - POSIT_ES;
  localparam int PFW = 2*FW + 1;

  logic          rts_i;
  logic          rtr_o;
  logic          a_sign;
  logic          b_sign;
  logic          a_inf;
  logic          b_inf;
  logic          a_zero;
  logic          b_zero;
  logic [SW-1:0] a_scale;
  logic [SW-1:0] b_scale;
  logic [FW-1:0] a_fraction;
  logic [FW-1:0] b_fraction;

  logic           rts_o;
  logic           rtr_i;
  logic           sign;
  logic           inf;
  logic           zero;
  logic [SW:0]    scale;
  logic [PFW-1:0] fraction;

  modport slave (
    input  rts_i, a_sign, b_sign, a_inf, b_inf, a_zero, b_zero,
           a_scale, b_scale, a_fraction, b_fraction, rtr_i,
    output rtr_o, rts_o, sign, inf, zero, scale, fraction
  );

  modport master (
    output rts_i, a_sign, b_sign, a_inf, b_inf, a_zero, b_zero,
           a_scale, b_scale, a_fraction, b_fraction, rtr_i,
    input  rtr_o, rts_o, sign, inf, zero, scale, fraction
  );
endinterface

// File: rtl/posit_mult_decoded.sv
// Two-stage pipelined multiplier on decoded posit operands, exact (unrounded) product.
// Optional POSIT_MULT_STATS_EN adds saturating NaR/product emit counters.
module posit_mult_decoded #(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  posit_mult_decoded_if.slave      bus
`ifdef POSIT_MULT_STATS_EN
  ,
  output logic [15:0]              nar_count,
  output logic [31:0]              prod_count
`endif
);
  localparam int SW  = $clog2(POSIT_WIDTH-1) + POSIT_ES + 1;
  localparam int FW  = POSIT_WIDTH - 3 - POSIT_ES;
  localparam int PFW = 2*FW + 1;
  localparam int MW  = 2*FW + 2;

  logic           w_s2_en;
  logic           w_s1_en;
  logic           w_inf_x;
  logic [SW:0]    w_scale_sum;
  logic [MW-1:0]  w_a_mant;
  logic [MW-1:0]  w_b_mant;
  logic [MW-1:0]  w_mant;
  logic           w_special;
  logic [SW:0]    w_nrm_scale;
  logic [PFW-1:0] w_nrm_fraction;

  logic           r_s1_v;
  logic           r_s1_sign;
  logic           r_s1_inf;
  logic           r_s1_zero;
  logic [SW:0]    r_s1_scale;
  logic [MW-1:0]  r_s1_mant;

  logic           r_s2_v;
  logic           r_sign;
  logic           r_inf;
  logic           r_zero;
  logic [SW:0]    r_scale;
  logic [PFW-1:0] r_fraction;

  assign w_s2_en   = !r_s2_v | bus.rtr_i;
  assign w_s1_en   = !r_s1_v | w_s2_en;
  // Reset clears both valids, so advertising ready during reset is always safe.
  assign bus.rtr_o = rst | w_s1_en;

  assign w_inf_x     = bus.a_inf | bus.b_inf;
  assign w_scale_sum = {bus.a_scale[SW-1], bus.a_scale} + {bus.b_scale[SW-1], bus.b_scale};
  assign w_a_mant    = {{(FW+1){1'b0}}, 1'b1, bus.a_fraction};
  assign w_b_mant    = {{(FW+1){1'b0}}, 1'b1, bus.b_fraction};
  assign w_mant      = w_a_mant * w_b_mant;

  // Product of two [1,2) mantissas lies in [1,4); MSB set means the scale bumps by one.
  always_comb begin
    w_nrm_scale    = r_s1_scale;
    w_nrm_fraction = {r_s1_mant[PFW-2:0], 1'b0};
    if (r_s1_mant[MW-1]) begin
      w_nrm_scale    = r_s1_scale + (SW+1)'(1);
      w_nrm_fraction = r_s1_mant[PFW-1:0];
    end
  end

  assign w_special = r_s1_inf | r_s1_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_scale <= '0;
      r_s1_mant  <= '0;
      r_s2_v     <= 1'b0;
      r_sign     <= 1'b0;
      r_inf      <= 1'b0;
      r_zero     <= 1'b0;
      r_scale    <= '0;
      r_fraction <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_v <= bus.rts_i;
      end
      if (w_s1_en && bus.rts_i) begin
        r_s1_sign  <= bus.a_sign ^ bus.b_sign;
        r_s1_inf   <= w_inf_x;
        r_s1_zero  <= !w_inf_x & (bus.a_zero | bus.b_zero);
        r_s1_scale <= w_scale_sum;
        r_s1_mant  <= w_mant;
      end
      if (w_s2_en) begin
        r_s2_v <= r_s1_v;
      end
      if (w_s2_en && r_s1_v) begin
        r_sign     <= r_s1_sign & !w_special;
        r_inf      <= r_s1_inf;
        r_zero     <= r_s1_zero;
        r_scale    <= w_special ? '0 : w_nrm_scale;
        r_fraction <= w_special ? '0 : w_nrm_fraction;
      end
    end
  end

  assign bus.rts_o    = r_s2_v;
  assign bus.sign     = r_sign;
  assign bus.inf      = r_inf;
  assign bus.zero     = r_zero;
  assign bus.scale    = r_scale;
  assign bus.fraction = r_fraction;

`ifdef POSIT_MULT_STATS_EN
  logic        w_emit;
  logic [15:0] r_nar_count;
  logic [31:0] r_prod_count;

  assign w_emit = r_s2_v & bus.rtr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nar_count  <= '0;
      r_prod_count <= '0;
    end else if (w_emit) begin
      if (r_inf && (r_nar_count != 16'hFFFF)) begin
        r_nar_count <= r_nar_count + 16'd1;
      end
      if (r_prod_count != 32'hFFFF_FFFF) begin
        r_prod_count <= r_prod_count + 32'd1;
      end
    end
  end

  assign nar_count  = r_nar_count;
  assign prod_count = r_prod_count;
`endif
endmodule

// File: tb/tb_posit_mult_decoded.sv
// Self-checking bench for posit_mult_decoded: directed cases, stall/reset flow,
// randomized traffic against an arithmetic reference model and scoreboard.
module tb_posit_mult_decoded;
  localparam int N   = 16;
  localparam int ES  = 0;
  localparam int SW  = $clog2(N-1) + ES + 1;
  localparam int FW  = N - 3 - ES;
  localparam int PFW = 2*FW + 1;
  localparam int RW  = 3 + SW + 1 + PFW;

  typedef struct packed {
    logic          s;
    logic          i;
    logic          z;
    logic [SW-1:0] sc;
    logic [FW-1:0] fr;
  } op_t;

  typedef struct {
    logic [RW-1:0] res;
    int            acc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_emit = 0;
  logic last_acc;
  logic last_rtr_o;
  logic prev_stall = 1'b0;
  logic [RW-1:0] prev_out;
  ent_t q[$];
  op_t  cur_a, cur_b;

  posit_mult_decoded_if #(.POSIT_WIDTH(N), .POSIT_ES(ES)) bus ();

`ifdef POSIT_MULT_STATS_EN
  logic [15:0] nar_count;
  logic [31:0] prod_count;
  posit_mult_decoded #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .nar_count(nar_count), .prod_count(prod_count));
`else
  posit_mult_decoded #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact product of (1+fa/2^FW)*(1+fb/2^FW) rescaled into [1,2).
  function automatic logic [RW-1:0] model(input op_t a, input op_t b);
    longint ma, mb, p, fr;
    int sc;
    logic [SW:0] sc_v;
    logic [PFW-1:0] fr_v;
    if (a.i || b.i) return {3'b010, {(SW+1+PFW){1'b0}}};
    if (a.z || b.z) return {3'b001, {(SW+1+PFW){1'b0}}};
    ma = (longint'(1) << FW) + longint'(a.fr);
    mb = (longint'(1) << FW) + longint'(b.fr);
    p  = ma * mb;
    sc = int'($signed(a.sc)) + int'($signed(b.sc));
    if (p >= (longint'(1) << (2*FW+1))) begin
      sc = sc + 1;
      fr = p - (longint'(1) << PFW);
    end else begin
      fr = (p - (longint'(1) << (2*FW))) * 2;
    end
    sc_v = sc[SW:0];
    fr_v = fr[PFW-1:0];
    return {a.s ^ b.s, 2'b00, sc_v, fr_v};
  endfunction

  function automatic op_t rand_op();
    logic [31:0] x, y;
    op_t o;
    x = $urandom();
    y = $urandom();
    o.s  = x[0];
    o.i  = (x[7:4] == 4'd0);
    o.z  = (x[11:8] == 4'd0);
    o.sc = x[16 +: SW];
    o.fr = y[FW-1:0];
    return o;
  endfunction

  function automatic op_t mk(input logic s, input logic i, input logic z,
                             input int sc, input int fr);
    op_t o;
    o.s = s; o.i = i; o.z = z;
    o.sc = sc[SW-1:0];
    o.fr = fr[FW-1:0];
    return o;
  endfunction

  task automatic set_ops(input op_t a, input op_t b);
    cur_a = a;
    cur_b = b;
    bus.a_sign = a.s;  bus.a_inf = a.i;  bus.a_zero = a.z;
    bus.a_scale = a.sc; bus.a_fraction = a.fr;
    bus.b_sign = b.s;  bus.b_inf = b.i;  bus.b_zero = b.z;
    bus.b_scale = b.sc; bus.b_fraction = b.fr;
  endtask

  // One clock: observe at negedge, update scoreboard, advance past posedge.
  task automatic step();
    logic [RW-1:0] out;
    logic exp_rts;
    @(negedge clk);
    out = {bus.sign, bus.inf, bus.zero, bus.scale, bus.fraction};
    last_rtr_o = bus.rtr_o;
    chk("rtr_o", 64'(bus.rtr_o), 64'(rst || bus.rtr_i || (q.size() < 2)));
    exp_rts = (q.size() > 0) && (cyc >= q[0].acc + 1);
    chk("rts_o", 64'(bus.rts_o), 64'(exp_rts));
    if (prev_stall) chk("stall_stable", 64'(out), 64'(prev_out));
    last_acc = 1'b0;
    if (!rst) begin
      if (bus.rts_o && bus.rtr_i) begin
        if (q.size() == 0) begin
          chk("unexpected_emit", 64'(1), 64'(0));
        end else begin
          chk("product", 64'(out), 64'(q[0].res));
          void'(q.pop_front());
        end
        n_emit++;
      end
      if (bus.rts_i && bus.rtr_o) begin
        q.push_back('{res: model(cur_a, cur_b), acc: cyc + 1});
        last_acc = 1'b1;
      end
    end
    prev_stall = bus.rts_o && !bus.rtr_i && !rst;
    prev_out   = out;
    if (rst) begin
      q.delete();
      n_emit = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic one_pair(input op_t a, input op_t b);
    bus.rtr_i = 1'b1;
    set_ops(a, b);
    bus.rts_i = 1'b1;
    step();
    bus.rts_i = 1'b0;
    step();
  endtask

  initial begin
    int sent;
    int drops;
    rst = 1'b1;
    bus.rts_i = 1'b0;
    bus.rtr_i = 1'b0;
    set_ops(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
    #1;
    chk("rtr_o_in_reset", 64'(bus.rtr_o), 64'(1));
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    chk("reset_rts_o", 64'(bus.rts_o), 64'(0));
    chk("reset_outputs", 64'({bus.sign, bus.inf, bus.zero, bus.scale, bus.fraction}), 64'(0));
    chk("reset_rtr_o", 64'(bus.rtr_o), 64'(1));

    // 1.5 * 1.5 = 2.25
    one_pair(mk(0, 0, 0, 0, 'h1000), mk(0, 0, 0, 0, 'h1000));
    chk("t1_rts_o", 64'(bus.rts_o), 64'(1));
    chk("t1_sign", 64'(bus.sign), 64'(0));
    chk("t1_scale", 64'(bus.scale), 64'(1));
    chk("t1_fraction", 64'(bus.fraction), 64'('h1000000));
    chk("t1_flags", 64'({bus.inf, bus.zero}), 64'(0));
    step();

    one_pair(mk(1, 0, 0, 3, 0), mk(0, 0, 0, -2, 0));
    chk("t2_rts_o", 64'(bus.rts_o), 64'(1));
    chk("t2_all", 64'({bus.sign, bus.inf, bus.zero, bus.scale, bus.fraction}),
        64'({1'b1, 2'b00, 6'd1, 27'd0}));
    step();

    one_pair(mk(1, 1, 0, 5, 'h0abc), mk(0, 0, 1, 2, 'h0123));
    chk("t3_nar", 64'({bus.sign, bus.inf, bus.zero, bus.scale, bus.fraction}),
        64'({3'b010, 6'd0, 27'd0}));
    step();
    one_pair(mk(1, 0, 1, 3, 'h1555), mk(0, 0, 0, 4, 'h0aaa));
    chk("t3_zero", 64'({bus.sign, bus.inf, bus.zero, bus.scale, bus.fraction}),
        64'({3'b001, 6'd0, 27'd0}));
    step();

    // Five back-to-back pairs with downstream stalled in cycles 3..6
    sent = 0;
    drops = 0;
    n_emit = 0;
    set_ops(rand_op(), rand_op());
    for (int c = 0; c < 40 && (sent < 5 || q.size() > 0); c++) begin
      bus.rtr_i = !(c >= 3 && c <= 6);
      bus.rts_i = (sent < 5);
      step();
      if (!last_rtr_o) drops++;
      if (last_acc) begin
        sent++;
        set_ops(rand_op(), rand_op());
      end
    end
    bus.rts_i = 1'b0;
    chk("stream_sent", 64'(sent), 64'(5));
    chk("stream_emitted", 64'(n_emit), 64'(5));
    chk("stream_drained", 64'(q.size()), 64'(0));
    chk("stream_rtr_dropped", 64'(drops > 0), 64'(1));

    // Reset with two pairs in flight
    bus.rtr_i = 1'b0;
    bus.rts_i = 1'b1;
    set_ops(rand_op(), rand_op());
    step();
    set_ops(rand_op(), rand_op());
    step();
    chk("rst_inflight", 64'(q.size()), 64'(2));
    bus.rts_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_rts_o", 64'(bus.rts_o), 64'(0));
    chk("rst_rtr_o", 64'(bus.rtr_o), 64'(1));
    bus.rtr_i = 1'b1;
    repeat (4) step();

`ifdef POSIT_MULT_STATS_EN
    n_emit = 0;
    bus.rtr_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 3) set_ops(mk(0, 1, 0, 0, 0), rand_op());
      else set_ops(mk(0, 0, 0, 1, k), mk(1, 0, 0, 2, k));
      bus.rts_i = 1'b1;
      step();
    end
    bus.rts_i = 1'b0;
    repeat (4) step();
    chk("stats_nar", 64'(nar_count), 64'(3));
    chk("stats_prod", 64'(prod_count), 64'(7));
    set_ops(mk(0, 1, 0, 0, 0), mk(0, 0, 0, 0, 0));
    bus.rts_i = 1'b1;
    repeat (65540) step();
    bus.rts_i = 1'b0;
    repeat (4) step();
    chk("stats_nar_sat", 64'(nar_count), 64'(16'hFFFF));
    chk("stats_prod_total", 64'(prod_count), 64'(n_emit));
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      set_ops(rand_op(), rand_op());
      bus.rts_i = ($urandom_range(0, 9) < 7);
      bus.rtr_i = ($urandom_range(0, 9) < 7);
      step();
    end
    bus.rts_i = 1'b0;
    bus.rtr_i = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    chk("random_drained", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
